cdc_fifo_wr_arbiter: RTL
========================

Name: cdc_fifo_wr_arbiter

Overview:
- Shares the write port of one cdc_async_fifo between N requesters in the FIFO write-clock domain.
- Grants whole bursts in round-robin order and holds the grant until the burst's last beat or a MAX_BURST cap.
- Does not start a new burst while the FIFO reports almost-full.
- Tags every written word with requester ID and last flag, so the read side can demultiplex and reframe.

Parameters:
- N, 4, number of requesters (≥2).
- DATA_WIDTH, 16, payload width per requester.
- MAX_BURST, 16, maximum beats per grant before forced release (≥1).
- ID_WIDTH, $clog2(N), requester ID field width.
- BCNT_WIDTH, $clog2(MAX_BURST+1), beat-counter width.

Ports:
- clk_i  in  1  FIFO write-domain clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  N  per-requester beat valid.
- req_last_i  in  N  per-requester last beat of burst.
- req_data_i  in  N*DATA_WIDTH  packed payloads; requester k at [k*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  out  N  per-requester beat accepted this cycle.
- fifo_wr_en_o  out  1  to FIFO wr_en_i.
- fifo_wr_data_o  out  DATA_WIDTH+ID_WIDTH+1  {id, last, data} to FIFO wr_data_i.
- fifo_full_i  in  1  from FIFO full_o.
- fifo_almost_full_i  in  1  from FIFO almost_full_o.
- grant_o  out  N  one-hot current grant, 0 when idle.
- busy_o  out  1  high in BURST state.

Behaviour:
- Reset (async assert, sync-to-clk deassert by the upstream reset synchronizer):
  - state=IDLE, grant_o=0, rr_ptr=0, beat_cnt=0, busy_o=0.
  - All outputs low; fifo_wr_data_o=0.
- Beat transfer (combinational):
  - xfer = busy_o & req_valid_i[g] & !fifo_full_i, where g is the granted index.
  - fifo_wr_en_o = xfer.
  - req_ready_o[g] = busy_o & !fifo_full_i; req_ready_o is 0 for every other requester.
  - fifo_wr_data_o = {g, req_last_i[g], req_data_i[g]}.
  - fifo_wr_en_o is never asserted while fifo_full_i=1, so the FIFO never overflows.
- State IDLE:
  - If any req_valid_i and !fifo_almost_full_i, select the first valid index scanning from rr_ptr upward with wrap.
  - Register the one-hot grant, clear beat_cnt, go to BURST.
  - No beat moves in IDLE; arbitration latency is 1 cycle from valid to first possible transfer.
- State BURST:
  - Each xfer increments beat_cnt.
  - Release when xfer and (req_last_i[g] or beat_cnt==MAX_BURST-1): go to IDLE, grant_o=0, rr_ptr = (g+1) mod N.
  - The release cycle's beat is written.
- Forced release:
  - After MAX_BURST beats without last, the requester must re-arbitrate.
  - Its burst continues under the same ID later; the last flag stays as driven by the requester.
- Stalls:
  - Valid low or FIFO full inside BURST holds the grant indefinitely with no timeout.
  - almost_full gates only new grants, never an in-progress burst.
- Requester contract: data and last must be stable while valid & !ready.
- Fairness: a requester waits at most N-1 bursts of ≤MAX_BURST beats each.
- Dropped valid: a valid dropped by a non-granted requester before grant has no effect.
- Reset mid-burst: the burst is abandoned immediately; state returns to IDLE with rr_ptr=0.

Test Plan:
- Fairness, all requesters active: N=4, all valid continuously with 3-beat bursts (last on beat 3), FIFO never full.
  - Grants go 0,1,2,3,0 in that order.
  - Each burst writes 3 words with IDs 0,0,0 then 1,1,1, and so on.
  - Exactly 1 idle cycle between bursts.
- Forced release: requester 2 alone, 40 beats, no last.
  - Three grants of 16, 16 and 8 beats.
  - fifo_wr_data_o last bit stays 0 throughout; the 1-cycle IDLE gap appears after beats 16 and 32.
- Full backpressure: assert fifo_full_i for 5 cycles mid-burst.
  - fifo_wr_en_o=0 and req_ready_o=0 for those 5 cycles.
  - The same beat data is written on the first non-full cycle; no beat is lost or duplicated.
- almost_full gating: fifo_almost_full_i=1 while in IDLE with requesters 1 and 3 valid.
  - grant_o stays 0 until almost_full drops; requester 1 is then granted next cycle.
  - Separately, almost_full rising during a burst does not stop that burst.
- Round-robin skip: rr_ptr=1 with only requesters 0 and 3 valid.
  - Requester 3 is granted first, then requester 0.
- Async reset: assert rst_ni low mid-burst on beat 5.
  - fifo_wr_en_o, grant_o and busy_o go 0 without waiting for a clock edge.
  - After release, requester 0 is granted first again.

Source files
------------

// File: rtl/cdc_fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle shared by the arbiter and its environment.
// valid/ready: a beat moves on a cycle where req_valid_i[g] and req_ready_o[g] are both high; data and last hold until then.
interface cdc_fifo_wr_arbiter_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = $clog2(N)
);
    logic [N-1:0]                     req_valid_i;
    logic [N-1:0]                     req_last_i;
    logic [N*DATA_WIDTH-1:0]          req_data_i;
    logic [N-1:0]                     req_ready_o;
    logic                             fifo_wr_en_o;
    logic [DATA_WIDTH+ID_WIDTH:0]     fifo_wr_data_o;
    logic                             fifo_full_i;
    logic                             fifo_almost_full_i;
    logic [N-1:0]                     grant_o;
    logic                             busy_o;

    modport master (
        output req_valid_i, req_last_i, req_data_i, fifo_full_i, fifo_almost_full_i,
        input  req_ready_o, fifo_wr_en_o, fifo_wr_data_o, grant_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_last_i, req_data_i, fifo_full_i, fifo_almost_full_i,
        output req_ready_o, fifo_wr_en_o, fifo_wr_data_o, grant_o, busy_o
    );
endinterface

// File: rtl/cdc_fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of a cdc_async_fifo.
// Each written word is tagged {id, last, data} so the read side can demultiplex.
module cdc_fifo_wr_arbiter #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 16,
    parameter int ID_WIDTH   = $clog2(N),
    parameter int BCNT_WIDTH = $clog2(MAX_BURST + 1)
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    cdc_fifo_wr_arbiter_if.slave bus
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [N-1:0]          grant_q, grant_d;
    logic [ID_WIDTH-1:0]   gidx_q, gidx_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BCNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

    logic                  busy;
    logic                  xfer;
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  pick_found;
    logic [ID_WIDTH-1:0]   pick_idx;

    assign busy    = (state_q == S_BURST);
    assign g_valid = bus.req_valid_i[gidx_q];
    assign g_last  = bus.req_last_i[gidx_q];
    assign g_data  = bus.req_data_i[int'(gidx_q) * DATA_WIDTH +: DATA_WIDTH];
    assign xfer    = busy & g_valid & ~bus.fifo_full_i;

    // grant_q is zero outside BURST, so masking it also gates ready in IDLE.
    assign bus.req_ready_o    = grant_q & {N{~bus.fifo_full_i}};
    assign bus.fifo_wr_en_o   = xfer;
    assign bus.fifo_wr_data_o = busy ? {gidx_q, g_last, g_data} : '0;
    assign bus.grant_o        = grant_q;
    assign bus.busy_o         = busy;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!pick_found && bus.req_valid_i[(int'(rr_ptr_q) + i) % N]) begin
                pick_found = 1'b1;
                pick_idx   = ID_WIDTH'((int'(rr_ptr_q) + i) % N);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found && !bus.fifo_almost_full_i) begin
                    state_d    = S_BURST;
                    gidx_d     = pick_idx;
                    grant_d    = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    // Release on last beat or at the cap; the release beat itself is written.
                    if (g_last || beat_cnt_q == BCNT_WIDTH'(MAX_BURST - 1)) begin
                        state_d  = S_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = (gidx_q == ID_WIDTH'(N - 1)) ? '0 : gidx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule
